// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and constants shared by the RV32M multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  localparam logic [63:0] DIVZ_Q = '1;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: shift-add / restoring shift-subtract datapath on a shared (W+1)-bit adder
module muldiv_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           neg_p,
  input  logic           neg_q,
  input  logic           neg_r,
  output logic [2*W-1:0] prod,
  output logic [W-1:0]   quo,
  output logic [W-1:0]   rem
);
  logic [W-1:0] acc, mq, bm;
  logic [W:0]   sum;
  // divide: {acc,next dividend bit} - divisor; sum[W] set means the trial went negative
  assign sum = (div ? {acc, mq[W-1]} : {1'b0, acc}) + (div ? ~{1'b0, bm} : {1'b0, bm}) + {{W{1'b0}}, div};
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      mq  <= '0;
      bm  <= '0;
    end else if (load) begin
      acc <= '0;
      mq  <= a;
      bm  <= b;
    end else if (step) begin
      if (div)
        {acc, mq} <= sum[W] ? {acc[W-2:0], mq, 1'b0} : {sum[W-1:0], mq[W-2:0], 1'b1};
      else
        {acc, mq} <= mq[0] ? {sum, mq[W-1:1]} : {1'b0, acc, mq[W-1:1]};
    end
  end
  assign prod = neg_p ? -{acc, mq} : {acc, mq};
  assign quo  = neg_q ? -mq : mq;
  assign rem  = neg_r ? -acc : acc;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide FSM with execute-stage handshake.
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and zero-operand multiplies in the start cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         startE,
  input  logic [2:0]   opE,
  input  logic [W-1:0] srcaE,
  input  logic [W-1:0] srcbE,
  input  logic         flushE,
  output logic         busyE,
  output logic         doneE,
  output logic [W-1:0] resultE
);
  localparam int CW = $clog2(W);
  state_e         state;
  logic [2:0]     op;
  logic           sa, sb, dz;
  logic [CW-1:0]  cnt;
  logic           sa_i, sb_i, start, early;
  logic [W-1:0]   am, bmag, early_res, sel, quo, rem;
  logic [2*W-1:0] prod;
  assign sa_i  = srcaE[W-1] & !(opE == OP_MULHU || opE == OP_DIVU || opE == OP_REMU);
  assign sb_i  = srcbE[W-1] & (opE == OP_MUL || opE == OP_MULH || opE == OP_DIV || opE == OP_REM);
  assign am    = sa_i ? -srcaE : srcaE;
  assign bmag  = sb_i ? -srcbE : srcbE;
  assign start = state == IDLE && startE && !flushE;
`ifdef MULDIV_EARLY_OUT_EN
  logic dz_i, ovf_i;
  assign dz_i      = srcbE == '0;
  assign ovf_i     = (opE == OP_DIV || opE == OP_REM) && srcaE == {1'b1, {(W-1){1'b0}}} && &srcbE;
  assign early     = opE[2] ? dz_i || ovf_i : srcaE == '0 || srcbE == '0;
  assign early_res = !opE[2] ? '0 : dz_i ? (opE[1] ? srcaE : DIVZ_Q[W-1:0]) : (opE[1] ? '0 : srcaE);
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif
  assign busyE = (state == IDLE && startE) || state == CALC || state == FIX;
  // the restoring divider already yields all-ones for x/0, but the sign fix would corrupt it
  assign sel = op == OP_MUL ? prod[W-1:0] : !op[2] ? prod[2*W-1:W] : !op[1] ? (dz ? DIVZ_Q[W-1:0] : quo) : rem;
  muldiv_core #(.W(W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (start && !early),
    .step  (state == CALC),
    .div   (op[2]),
    .a     (am),
    .b     (bmag),
    .neg_p (sa ^ sb),
    .neg_q ((sa ^ sb) && !dz),
    .neg_r (sa),
    .prod  (prod),
    .quo   (quo),
    .rem   (rem)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      resultE <= '0;
      doneE   <= 1'b0;
      op      <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      dz      <= 1'b0;
    end else begin
      doneE <= 1'b0;
      if (flushE && state != IDLE)
        state <= IDLE;
      else
        case (state)
          IDLE: if (start) begin
            op  <= opE;
            sa  <= sa_i;
            sb  <= sb_i;
            dz  <= srcbE == '0;
            cnt <= CW'(W - 1);
            if (early) begin
              state   <= DONE;
              resultE <= early_res;
              doneE   <= 1'b1;
            end else
              state <= CALC;
          end
          CALC: if (cnt == '0) state <= FIX; else cnt <= cnt - 1'b1;
          FIX: begin
            state   <= DONE;
            resultE <= sel;
            doneE   <= 1'b1;
          end
          DONE: state <= IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit (W=32)
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 34;
`endif
  logic        clk, rst, startE, flushE, busyE, doneE;
  logic [2:0]  opE;
  logic [31:0] srcaE, srcbE, resultE, last_res;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          compared, mismatched;

  muldiv_unit #(.W(32)) dut (
    .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
    .flushE(flushE), .busyE(busyE), .doneE(doneE), .resultE(resultE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input int lat, input bit push);
    opE = op; srcaE = a; srcbE = b; startE = 1'b1;
    if (push) begin exp_q.push_back(e); lat_q.push_back(lat); end
    #1 chk({tag, "_busy0"}, {31'b0, busyE}, 32'd1);
    @(posedge clk); #1 startE = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int pulse);
    int n, busy_bad, el;
    logic [31:0] e;
    n = 0; busy_bad = 0;
    e = exp_q.pop_front(); el = lat_q.pop_front();
    do begin
      @(negedge clk); n++;
      startE = (n == pulse);
      if (!doneE && !busyE) busy_bad++;
    end while (!doneE && n < 100);
    startE = 1'b0;
    chk({tag, "_res"}, resultE, e);
    chk({tag, "_lat"}, n, el);
    chk({tag, "_busyhold"}, busy_bad, 0);
    chk({tag, "_busydone"}, {31'b0, busyE}, 32'd0);
    last_res = e;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, doneE}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input int lat);
    start_op(tag, op, a, b, e, lat, 1'b1);
    wait_done(tag, 0);
  endtask

  initial begin
    int extra;
    compared = 0; mismatched = 0;
    rst = 1'b1; startE = 1'b0; flushE = 1'b0; opE = '0; srcaE = '0; srcbE = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_busy", {31'b0, busyE}, 32'd0);
    chk("rst_done", {31'b0, doneE}, 32'd0);
    chk("rst_res", resultE, 32'd0);

    run("mul", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run("mulh", MULH, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run("mul_big", MUL, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, 34);
    run("div", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run("rem", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run("divu", DIVU, 32'd100, 32'd7, 32'd14, 34);
    run("remu", REMU, 32'd100, 32'd7, 32'd2, 34);
    run("div_z", DIV, 32'd5, 32'd0, 32'hFFFFFFFF, EL);
    run("rem_z", REM, 32'd5, 32'd0, 32'd5, EL);
    run("divneg_z", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, EL);
    run("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, EL);
    run("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, EL);
    run("mul_zero", MUL, 32'd0, 32'd5, 32'd0, EL);

    // startE pulsed in cycle 5 of a divide must be ignored
    start_op("ign", DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    opE = MUL; srcaE = 32'd3; srcbE = 32'd3;
    wait_done("ign", 5);
    extra = 0;
    repeat (40) begin @(negedge clk); if (doneE) extra++; end
    chk("ign_single_done", extra, 0);

    // flush in cycle 10 of a multiply
    start_op("flush", MUL, 32'd3, 32'd4, 32'd0, 0, 1'b0);
    extra = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (doneE) extra++;
      if (k == 10) flushE = 1'b1;
    end
    @(negedge clk); flushE = 1'b0;
    chk("flush_busy", {31'b0, busyE}, 32'd0);
    chk("flush_done", {31'b0, doneE || extra != 0}, 32'd0);
    chk("flush_keep", resultE, last_res);
    @(negedge clk);
    run("after_flush", DIVU, 32'd9, 32'd3, 32'd3, 34);

    // reset in cycle 15 of a divide
    start_op("rstmid", DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 0, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_res", resultE, 32'd0);
    chk("rstmid_done", {31'b0, doneE}, 32'd0);
    chk("rstmid_busy", {31'b0, busyE}, 32'd0);
    @(negedge clk); rst = 1'b0;
    extra = 0;
    repeat (40) begin @(negedge clk); if (doneE || busyE) extra++; end
    chk("rstmid_quiet", extra, 0);
    run("after_rst", REM, 32'd17, 32'hFFFFFFFB, 32'd2, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the RV32M extension, placed in the execute stage beside the single-cycle ALU.
- Accepts one operation from the execute stage and sequences a shared (W+1)-bit add/subtract datapath over W iterations.
- Holds the pipeline with busyE while it works, then returns the result with a one-cycle doneE pulse.

Parameters:
- W, 32, operand/result width; the iteration count equals W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- startE  input  1  execute-stage request; sampled only in IDLE
- opE  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srcaE  input  W  operand a (multiplicand/dividend)
- srcbE  input  W  operand b (multiplier/divisor)
- flushE  input  1  abort the current operation (branch/trap flush)
- busyE  output  1  stall request to the hazard unit
- doneE  output  1  one-cycle result-valid strobe
- resultE  output  W  result register, valid when doneE=1

Behaviour:
- One clock; reset is synchronous, active-high. rst=1 at an edge forces state IDLE, counter 0, resultE 0, doneE 0. busyE is 0 while in IDLE with startE=0. rst overrides everything, including mid-operation.
- FSM states and transitions:
  - IDLE -> CALC on startE=1. On that edge: latch opE; latch operand magnitudes and sign flags (MULHSU treats b as unsigned; the U ops are unsigned); clear the accumulator; load counter = W-1.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter decrements. At counter==0 -> FIX.
  - FIX: conditional two's-complement negation, then select the output.
    - Product is negated when the operand signs differ (signed ops only).
    - Quotient is negated when the signs differ.
    - Remainder takes the sign of the dividend.
    - MUL selects the low W bits; MULH/MULHSU/MULHU select the high W bits. FIX -> DONE.
  - DONE: resultE registered, doneE=1 for exactly this cycle. DONE -> IDLE unconditionally.
- Latency: with start sampled at cycle 0, CALC occupies cycles 1..W, FIX is cycle W+1, and doneE=1 in cycle W+2 (cycle 34 for W=32).
- busyE = (IDLE and startE) or CALC or FIX. It is combinational in the start cycle so the same instruction holds in the execute stage. busyE=0 in DONE, so the pipeline advances on the doneE cycle.
- startE is ignored in CALC, FIX and DONE. No queueing.
- flushE=1 in any non-IDLE state -> IDLE at the next edge. No doneE; resultE keeps its previous value. flushE in IDLE has no effect; flushE takes priority over startE in the same cycle.
- Special cases (RISC-V defined):
  - Divide by zero: quotient all-ones, remainder = dividend.
  - DIV/REM of -2^(W-1) by -1: quotient -2^(W-1), remainder 0.
  - These results are produced at normal latency unless the optional feature is enabled.
- resultE holds its last value outside DONE. Consumers use it only when doneE=1.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in the start cycle, these cases go IDLE -> DONE directly, with doneE at cycle 1 and busyE=1 only in cycle 0:
  - divide by zero
  - signed overflow
  - either multiply operand zero (result 0)
- Undefined: every operation takes W+2 cycles and the special-case values come from FIX.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum for op (the funct3 encodings above)
  - typedef enum for state (IDLE, CALC, FIX, DONE)
  - constant for the divide-by-zero quotient (all-ones)
- One natural sub-module, muldiv_core: accumulator/partial-remainder and operand shift registers plus the shared (W+1)-bit adder/subtractor, with step/load/negate controls.
- muldiv_unit keeps the FSM, the counter, the special-case detection and the handshake logic.

Test Plan:
- MUL 7, -3 (0xFFFFFFFD) -> resultE=0xFFFFFFEB, doneE high exactly at cycle 34 for one cycle; busyE high cycles 0-33, low at 34.
- MULH 0x80000000,0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7,2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100,7 -> 14; REMU 100,7 -> 2.
- DIV 5,0 -> 0xFFFFFFFF; REM 5,0 -> 5; DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM same operands -> 0. With MULDIV_EARLY_OUT_EN, each doneE arrives at cycle 1.
- MUL started, flushE at cycle 10 -> busyE=0 and state IDLE at cycle 11, no doneE; a new DIVU 9,3 started at cycle 12 -> 3 at cycle 46.
- rst at cycle 15 of a DIV -> resultE=0, doneE=0, busyE=0 after the edge; a startE pulse during CALC is ignored (single doneE, original result).
